count_sequencer: RTL and testbench

Controller that sequences a WIDTH-bit free-running up-counter through a programmed number of full wrap-arounds.
- Provides a start/busy/done handshake, pause/resume, abort and continuous modes.
- Sits between a host control FSM and the counter datapath; the counter is owned internally so the counter value and wrap progress are always coherent.

---
 rtl/count_sequencer_if.sv | 27 ++
 rtl/count_sequencer.sv | 110 +++++++++++
 tb/tb_count_sequencer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/count_sequencer_if.sv
// Host-side control/status bundle for count_sequencer.
// The host drives the request signals; the sequencer drives counter status.
interface count_sequencer_if #(
  parameter int WIDTH  = 2,
  parameter int WRAP_W = 8
) ();

  logic              start;
  logic [WRAP_W-1:0] num_wraps;
  logic              pause;
  logic              stop;
  logic [WIDTH-1:0]  q;
  logic [WRAP_W-1:0] wrap_cnt;
  logic              busy;
  logic              done;

  modport master (
    output start, num_wraps, pause, stop,
    input  q, wrap_cnt, busy, done
  );

  modport slave (
    input  start, num_wraps, pause, stop,
    output q, wrap_cnt, busy, done
  );

endinterface

// File: rtl/count_sequencer.sv
// Sequences an internal WIDTH-bit up-counter through a programmed number of
// full wrap-arounds with start/busy/done handshake, pause, abort and continuous mode.
module count_sequencer #(
  parameter int WIDTH  = 2,
  parameter int WRAP_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  count_sequencer_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  q_r;
  logic [WRAP_W-1:0] wrap_r;
  logic [WRAP_W-1:0] target_r;
  logic              busy_r;
  logic              done_r;

  logic              q_max;
  logic [WRAP_W-1:0] wrap_inc;
  logic              hit_target;

  assign q_max      = &q_r;
  assign wrap_inc   = wrap_r + WRAP_W'(1);
  // target of zero selects continuous mode: the run never completes
  assign hit_target = (target_r != '0) && (wrap_inc == target_r);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      q_r      <= '0;
      wrap_r   <= '0;
      target_r <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          q_r    <= '0;
          done_r <= 1'b0;
          if (!bus.stop && bus.start) begin
            target_r <= bus.num_wraps;
            wrap_r   <= '0;
            busy_r   <= 1'b1;
            state    <= RUN;
          end
        end

        RUN: begin
          if (bus.stop) begin
            q_r    <= '0;
            busy_r <= 1'b0;
            state  <= IDLE;
          end else if (bus.pause) begin
            state <= PAUSE;
          end else begin
            q_r <= q_r + WIDTH'(1);
            if (q_max) begin
              wrap_r <= wrap_inc;
              if (hit_target) begin
                q_r    <= '0;
                busy_r <= 1'b0;
                done_r <= 1'b1;
                state  <= DONE;
              end
            end
          end
        end

        PAUSE: begin
          if (bus.stop) begin
            q_r    <= '0;
            busy_r <= 1'b0;
            state  <= IDLE;
          end else if (!bus.pause) begin
            // resume edge only re-enters RUN; counting continues on the next edge
            state <= RUN;
          end
        end

        DONE: begin
          q_r    <= '0;
          done_r <= 1'b0;
          busy_r <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          q_r    <= '0;
          busy_r <= 1'b0;
          done_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.q        = q_r;
  assign bus.wrap_cnt = wrap_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;

endmodule

// File: tb/tb_count_sequencer.sv
// Directed self-checking bench for count_sequencer (WIDTH=2, WRAP_W=8).
module tb_count_sequencer;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  count_sequencer_if #(.WIDTH(2), .WRAP_W(8)) bus ();

  count_sequencer #(.WIDTH(2), .WRAP_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input int eq, input int ewc, input int ebusy, input int edone);
    check({tag, ".q"},        32'(bus.q),        eq);
    check({tag, ".wrap_cnt"}, 32'(bus.wrap_cnt), ewc);
    check({tag, ".busy"},     32'(bus.busy),     ebusy);
    check({tag, ".done"},     32'(bus.done),     edone);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int kk;
    n_checks      = 0;
    n_errors      = 0;
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.num_wraps = '0;
    bus.pause     = 1'b0;
    bus.stop      = 1'b0;
    tick();
    tick();
    check_all("reset", 0, 0, 0, 0);

    // idle with non-start inputs toggling
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.pause     = i[0];
      bus.stop      = i[1];
      bus.num_wraps = 8'(i + 2);
      tick();
      check_all("idle", 0, 0, 0, 0);
    end
    bus.pause = 1'b0;
    bus.stop  = 1'b0;

    // single wrap: q 0,1,2,3 then done on the 4th edge
    bus.num_wraps = 8'd1;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    check_all("one.accept", 0, 0, 1, 0);
    tick(); check_all("one.e1", 1, 0, 1, 0);
    tick(); check_all("one.e2", 2, 0, 1, 0);
    tick(); check_all("one.e3", 3, 0, 1, 0);
    tick(); check_all("one.e4", 0, 1, 0, 1);
    tick(); check_all("one.e5", 0, 1, 0, 0);

    // three wraps, pause sampled on edges 7 and 8 (q=2 in 2nd wrap),
    // start re-pulsed while busy (edge 3) and in DONE (edge 16)
    bus.num_wraps = 8'd3;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    check_all("pz.accept", 0, 0, 1, 0);
    for (int k = 1; k <= 15; k++) begin
      bus.pause     = (k == 7 || k == 8);
      bus.start     = (k == 3);
      bus.num_wraps = (k == 3) ? 8'd1 : 8'd3;
      tick();
      kk = (k <= 6) ? k : ((k <= 9) ? 6 : k - 3);
      if (k == 15) check_all($sformatf("pz.e%0d", k), 0, 3, 0, 1);
      else         check_all($sformatf("pz.e%0d", k), kk % 4, kk / 4, 1, 0);
    end
    bus.pause     = 1'b0;
    bus.start     = 1'b1;
    bus.num_wraps = 8'd5;
    tick();
    bus.start = 1'b0;
    check_all("pz.done_start", 0, 3, 0, 0);
    tick();
    check_all("pz.idle", 0, 3, 0, 0);

    // continuous mode for 20 edges, then stop
    bus.num_wraps = 8'd0;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    check_all("cont.accept", 0, 0, 1, 0);
    for (int k = 1; k <= 20; k++) begin
      tick();
      check_all($sformatf("cont.e%0d", k), k % 4, k / 4, 1, 0);
    end
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    check_all("cont.stop", 0, 5, 0, 0);
    tick();
    check_all("cont.after", 0, 5, 0, 0);

    // start and stop together in IDLE: stop wins
    bus.num_wraps = 8'd1;
    bus.start     = 1'b1;
    bus.stop      = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    check_all("ss.idle", 0, 5, 0, 0);

    // stop and pause together in RUN: back to IDLE
    bus.num_wraps = 8'd2;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(); check_all("sp.e1", 1, 0, 1, 0);
    bus.stop  = 1'b1;
    bus.pause = 1'b1;
    tick();
    bus.stop  = 1'b0;
    bus.pause = 1'b0;
    check_all("sp.stop", 0, 0, 0, 0);

    // stop while paused keeps the partial wrap count
    bus.num_wraps = 8'd4;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 1; k <= 5; k++) tick();
    check_all("ps.e5", 1, 1, 1, 0);
    bus.pause = 1'b1;
    tick(); check_all("ps.pause", 1, 1, 1, 0);
    bus.stop = 1'b1;
    tick();
    bus.stop  = 1'b0;
    bus.pause = 1'b0;
    check_all("ps.stop", 0, 1, 0, 0);

    // reset mid-run at q=2
    bus.num_wraps = 8'd2;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick(); check_all("rr.e2", 2, 0, 1, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_all("rr.reset", 0, 0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      tick();
      check_all($sformatf("rr.idle%0d", k), 0, 0, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
